// File: rtl/control_multi.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute over a shared memory port and ALU.
// Outputs are registered decodes of the next state; only the fetch and store handshakes see mem_ready.
module control_multi #(
   parameter int unsigned STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         opcode,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               MemtoReg,
   output logic               RegDst,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ALUOp,
   output logic [1:0]         PCSource,
   output logic               zero_extnd,
   output logic               instr_done,
   output logic               illegal,
   output logic [STATE_W-1:0] state
);

   localparam logic [5:0] OpRtype = 6'd0;
   localparam logic [5:0] OpLw    = 6'd35;
   localparam logic [5:0] OpSw    = 6'd43;
   localparam logic [5:0] OpBeq   = 6'd4;
   localparam logic [5:0] OpJ     = 6'd2;
   localparam logic [5:0] OpOri   = 6'd13;

   typedef enum logic [STATE_W-1:0] {
      StReset, StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
      StRExec, StRWb, StBranch, StJump, StOriEx, StOriWb, StTrap
   } state_e;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       ior_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       zero_extnd;
      logic       done;
      logic       ill;
      logic       fetch;   // IR/PC load gated by mem_ready
      logic       memwr;   // store completes (and retires) in the mem_ready cycle
   } ctl_t;

   state_e state_q, state_d;
   ctl_t   ctl_q;

   function automatic ctl_t decode(state_e s);
      ctl_t c;
      c = '0;
      case (s)
         StFetch: begin
            c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.fetch = 1'b1;
         end
         StDecode: c.alu_src_b = 2'b11;
         StMemAdr: begin
            c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
         end
         StMemRd: begin
            c.mem_read = 1'b1; c.ior_d = 1'b1;
         end
         StMemWb: begin
            c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.done = 1'b1;
         end
         StMemWr: begin
            c.mem_write = 1'b1; c.ior_d = 1'b1; c.memwr = 1'b1;
         end
         StRExec: begin
            c.alu_src_a = 1'b1; c.alu_op = 2'b10;
         end
         StRWb: begin
            c.reg_write = 1'b1; c.reg_dst = 1'b1; c.done = 1'b1;
         end
         StBranch: begin
            c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1;
            c.pc_source = 2'b01; c.done = 1'b1;
         end
         StJump: begin
            c.pc_write = 1'b1; c.pc_source = 2'b10; c.done = 1'b1;
         end
         StOriEx: begin
            c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; c.zero_extnd = 1'b1;
         end
         StOriWb: begin
            c.reg_write = 1'b1; c.zero_extnd = 1'b1; c.done = 1'b1;
         end
         StTrap:  c.ill = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      state_d = state_q;
      case (state_q)
         StReset:  state_d = StFetch;
         StFetch:  if (mem_ready) state_d = StDecode;
         StDecode: begin
            case (opcode)
               OpRtype:     state_d = StRExec;
               OpLw, OpSw:  state_d = StMemAdr;
               OpBeq:       state_d = StBranch;
               OpJ:         state_d = StJump;
               OpOri:       state_d = StOriEx;
               default:     state_d = StTrap;
            endcase
         end
         StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
         StMemRd:  if (mem_ready) state_d = StMemWb;
         StMemWb:  state_d = StFetch;
         StMemWr:  if (mem_ready) state_d = StFetch;
         StRExec:  state_d = StRWb;
         StRWb:    state_d = StFetch;
         StBranch: state_d = StFetch;
         StJump:   state_d = StFetch;
         StOriEx:  state_d = StOriWb;
         StOriWb:  state_d = StFetch;
         StTrap:   state_d = StTrap;
         default:  state_d = StReset;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StReset;
         ctl_q   <= '0;
      end else begin
         state_q <= state_d;
         ctl_q   <= decode(state_d);
      end
   end

   assign PCWrite     = ctl_q.pc_write | (ctl_q.fetch & mem_ready);
   assign PCWriteCond = ctl_q.pc_write_cond;
   assign IorD        = ctl_q.ior_d;
   assign MemRead     = ctl_q.mem_read;
   assign MemWrite    = ctl_q.mem_write;
   assign IRWrite     = ctl_q.fetch & mem_ready;
   assign MemtoReg    = ctl_q.mem_to_reg;
   assign RegDst      = ctl_q.reg_dst;
   assign RegWrite    = ctl_q.reg_write;
   assign ALUSrcA     = ctl_q.alu_src_a;
   assign ALUSrcB     = ctl_q.alu_src_b;
   assign ALUOp       = ctl_q.alu_op;
   assign PCSource    = ctl_q.pc_source;
   assign zero_extnd  = ctl_q.zero_extnd;
   assign instr_done  = ctl_q.done | (ctl_q.memwr & mem_ready);
   assign illegal     = ctl_q.ill;
   assign state       = state_q;

endmodule

// File: tb/tb_control_multi.sv
// Directed bench for control_multi: per-cycle vector table plus instruction cycle-count sequences.
module tb_control_multi;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = 6'd0;
   logic       mem_ready = 1'b0;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst;
   logic       RegWrite, ALUSrcA, zero_extnd, instr_done, illegal;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic [3:0] state;

   int total = 0;
   int bad   = 0;

   control_multi #(.STATE_W(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .zero_extnd(zero_extnd), .instr_done(instr_done),
      .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   localparam logic [3:0] S_RESET = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2, S_MEMADR = 4'd3,
                          S_MEMRD = 4'd4,  S_MEMWB = 4'd5,  S_MEMWR = 4'd6,  S_REXEC = 4'd7,
                          S_RWB = 4'd8,    S_BRANCH = 4'd9, S_JUMP = 4'd10,  S_ORIEX = 4'd11,
                          S_ORIWB = 4'd12, S_TRAP = 4'd13;

   // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,
   //  ALUSrcB,ALUOp,PCSource,zero_extnd,instr_done,illegal}
   localparam logic [18:0] O_ZERO   = 19'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0_0;
   localparam logic [18:0] O_FETCH  = 19'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0_0;
   localparam logic [18:0] O_FWAIT  = 19'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0_0;
   localparam logic [18:0] O_DECODE = 19'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0_0;
   localparam logic [18:0] O_MEMADR = 19'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0_0;
   localparam logic [18:0] O_MEMRD  = 19'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0_0;
   localparam logic [18:0] O_MEMWB  = 19'b0_0_0_0_0_0_1_0_1_0_00_00_00_0_1_0;
   localparam logic [18:0] O_MEMWR  = 19'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_1_0;
   localparam logic [18:0] O_WWAIT  = 19'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0_0;
   localparam logic [18:0] O_REXEC  = 19'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0_0;
   localparam logic [18:0] O_RWB    = 19'b0_0_0_0_0_0_0_1_1_0_00_00_00_0_1_0;
   localparam logic [18:0] O_BRANCH = 19'b0_1_0_0_0_0_0_0_0_1_00_01_01_0_1_0;
   localparam logic [18:0] O_JUMP   = 19'b1_0_0_0_0_0_0_0_0_0_00_00_10_0_1_0;
   localparam logic [18:0] O_ORIEX  = 19'b0_0_0_0_0_0_0_0_0_1_10_11_00_1_0_0;
   localparam logic [18:0] O_ORIWB  = 19'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_1_0;
   localparam logic [18:0] O_TRAP   = 19'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0_1;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic        rdy;
      logic [3:0]  st;
      logic [18:0] outs;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic [5:0] op, input logic rdy,
                      input logic [3:0] st, input logic [18:0] outs);
      vec_t v;
      v.rst = r; v.op = op; v.rdy = rdy; v.st = st; v.outs = outs;
      vecs.push_back(v);
   endtask

   function automatic logic [18:0] got_outs();
      return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
              RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, zero_extnd, instr_done, illegal};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic measure(input logic [5:0] op, input int exp);
      int  n;
      bit  seen;
      n = 0;
      seen = 1'b0;
      mem_ready = 1'b1;
      opcode = op;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         n++;
         if (instr_done) seen = 1'b1;
         @(posedge clk); #1;
      end
      check($sformatf("cycles_op%0d", op), seen ? n : -1, exp);
   endtask

   initial begin
      // Full back-to-back sequence, mem_ready=1 (instr_done at cycles 4,9,13,16,19,23)
      add(0, 0, 1, S_FETCH, O_FETCH);   add(0, 0, 1, S_DECODE, O_DECODE);
      add(0, 0, 1, S_REXEC, O_REXEC);   add(0, 0, 1, S_RWB, O_RWB);
      add(0, 35, 1, S_FETCH, O_FETCH);  add(0, 35, 1, S_DECODE, O_DECODE);
      add(0, 35, 1, S_MEMADR, O_MEMADR); add(0, 35, 1, S_MEMRD, O_MEMRD);
      add(0, 35, 1, S_MEMWB, O_MEMWB);
      add(0, 43, 1, S_FETCH, O_FETCH);  add(0, 43, 1, S_DECODE, O_DECODE);
      add(0, 43, 1, S_MEMADR, O_MEMADR); add(0, 43, 1, S_MEMWR, O_MEMWR);
      add(0, 4, 1, S_FETCH, O_FETCH);   add(0, 4, 1, S_DECODE, O_DECODE);
      add(0, 4, 1, S_BRANCH, O_BRANCH);
      add(0, 2, 1, S_FETCH, O_FETCH);   add(0, 2, 1, S_DECODE, O_DECODE);
      add(0, 2, 1, S_JUMP, O_JUMP);
      add(0, 13, 1, S_FETCH, O_FETCH);  add(0, 13, 1, S_DECODE, O_DECODE);
      add(0, 13, 1, S_ORIEX, O_ORIEX);  add(0, 13, 1, S_ORIWB, O_ORIWB);
      // Fetch stall: 3 wait cycles then fetch completes
      for (int i = 0; i < 3; i++) add(0, 0, 0, S_FETCH, O_FWAIT);
      add(0, 0, 1, S_FETCH, O_FETCH);   add(0, 0, 1, S_DECODE, O_DECODE);
      add(0, 0, 1, S_REXEC, O_REXEC);   add(0, 0, 1, S_RWB, O_RWB);
      // Load with 2 wait cycles in MEMRD: 7 cycles total
      add(0, 35, 1, S_FETCH, O_FETCH);  add(0, 35, 1, S_DECODE, O_DECODE);
      add(0, 35, 1, S_MEMADR, O_MEMADR);
      add(0, 35, 0, S_MEMRD, O_MEMRD);  add(0, 35, 0, S_MEMRD, O_MEMRD);
      add(0, 35, 1, S_MEMRD, O_MEMRD);  add(0, 35, 1, S_MEMWB, O_MEMWB);
      // Store with one wait cycle
      add(0, 43, 1, S_FETCH, O_FETCH);  add(0, 43, 1, S_DECODE, O_DECODE);
      add(0, 43, 1, S_MEMADR, O_MEMADR); add(0, 43, 0, S_MEMWR, O_WWAIT);
      add(0, 43, 1, S_MEMWR, O_MEMWR);
      // Reset mid-store: no instr_done, RESET next cycle
      add(0, 43, 1, S_FETCH, O_FETCH);  add(0, 43, 1, S_DECODE, O_DECODE);
      add(0, 43, 1, S_MEMADR, O_MEMADR); add(1, 43, 0, S_MEMWR, O_WWAIT);
      add(0, 43, 0, S_RESET, O_ZERO);   add(0, 43, 0, S_FETCH, O_FWAIT);
      // Illegal opcode traps until reset
      add(0, 8, 1, S_FETCH, O_FETCH);   add(0, 8, 1, S_DECODE, O_DECODE);
      for (int i = 0; i < 12; i++) add(0, 8, 1, S_TRAP, O_TRAP);
      add(1, 8, 1, S_TRAP, O_TRAP);     add(0, 0, 1, S_RESET, O_ZERO);

      // Reset held 3 cycles, then one RESET cycle after release
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("rst_state", 32'(state), 32'(S_RESET));
         check("rst_outs", 32'(got_outs()), 32'(O_ZERO));
      end
      rst = 1'b0;
      @(negedge clk);
      check("rel_state", 32'(state), 32'(S_RESET));
      check("rel_outs", 32'(got_outs()), 32'(O_ZERO));
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         rst = vecs[i].rst;
         opcode = vecs[i].op;
         mem_ready = vecs[i].rdy;
         @(negedge clk);
         check($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].st));
         check($sformatf("v%0d_outs", i), 32'(got_outs()), 32'(vecs[i].outs));
         check($sformatf("v%0d_rdwr", i), 32'(MemRead & MemWrite), 32'd0);
         check($sformatf("v%0d_rwpc", i), 32'(RegWrite & PCWrite), 32'd0);
         @(posedge clk); #1;
      end
      rst = 1'b0;

      // Instruction latencies from FETCH entry with mem_ready=1
      measure(6'd0, 4);
      measure(6'd35, 5);
      measure(6'd43, 4);
      measure(6'd4, 3);
      measure(6'd2, 3);
      measure(6'd13, 4);
      @(negedge clk);
      check("after_seq_state", 32'(state), 32'(S_FETCH));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
